// File: rtl/ones_window_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ones_window_monitor
// Description : Converts the wrapping running ones count from the upstream
//               counter into per-window totals of WIN_LEN cycles. Each total
//               is compared against THRESH and queued in a 2-entry
//               valid/ready buffer. Results that arrive while the buffer is
//               full and is not draining are discarded and flagged on drop.
// Revision    : 1.0 - initial release
// ============================================================================
module ones_window_monitor #(
    parameter int CNT_W   = 4,
    parameter int WIN_LEN = 16,
    parameter int SUM_W   = 8,
    parameter int THRESH  = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] count,
    output logic [SUM_W-1:0] win_sum,
    output logic             win_alarm,
    output logic             win_valid,
    input  logic             win_ready,
    output logic             drop
);

    localparam int                 c_CYC_W  = $clog2(WIN_LEN);
    localparam logic [c_CYC_W-1:0] c_LAST   = c_CYC_W'(WIN_LEN - 1);
    localparam logic [SUM_W:0]     c_THRESH = (SUM_W + 1)'(THRESH);

    typedef enum logic [0:0] {
        S_PRIME = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_prev;
    logic [SUM_W-1:0]   r_acc;
    logic [c_CYC_W-1:0] r_cyc;

    // Buffer: head lives directly in the output registers, tail behind it.
    logic [SUM_W-1:0]   r_head_sum;
    logic               r_head_alarm;
    logic [SUM_W-1:0]   r_tail_sum;
    logic               r_tail_alarm;
    logic               r_valid;
    logic               r_full;
    logic               r_drop;

    logic [CNT_W-1:0]   w_delta;
    logic [SUM_W:0]     w_sum_ext;
    logic [SUM_W-1:0]   w_final;
    logic               w_alarm_new;
    logic               w_push;
    logic               w_pop;

    // Modulo difference handles the counter wrap; the sum saturates at all-ones.
    always_comb begin
        w_delta     = count - r_prev;
        w_sum_ext   = {1'b0, r_acc} + (SUM_W + 1)'(w_delta);
        w_final     = w_sum_ext[SUM_W] ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];
        w_alarm_new = ({1'b0, w_final} >= c_THRESH);
        w_push      = (r_state == S_ACCUM) && (r_cyc == c_LAST);
        w_pop       = r_valid && win_ready;
    end

    // Window FSM: prime the previous-count sample, then accumulate deltas
    // back to back, restarting the accumulator at every window close.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_PRIME;
            r_prev  <= '0;
            r_acc   <= '0;
            r_cyc   <= '0;
        end else begin
            case (r_state)
                S_PRIME: begin
                    r_prev  <= count;
                    r_acc   <= '0;
                    r_cyc   <= '0;
                    r_state <= S_ACCUM;
                end
                S_ACCUM: begin
                    r_prev <= count;
                    if (r_cyc == c_LAST) begin
                        r_acc <= '0;
                        r_cyc <= '0;
                    end else begin
                        r_acc <= w_final;
                        r_cyc <= r_cyc + c_CYC_W'(1);
                    end
                end
                default: r_state <= S_PRIME;
            endcase
        end
    end

    // Two-entry result buffer; head registers stay put when nothing moves,
    // so the outputs are stable under backpressure and after draining.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head_sum   <= '0;
            r_head_alarm <= 1'b0;
            r_tail_sum   <= '0;
            r_tail_alarm <= 1'b0;
            r_valid      <= 1'b0;
            r_full       <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (w_push && !w_pop) begin
                if (!r_valid) begin
                    r_head_sum   <= w_final;
                    r_head_alarm <= w_alarm_new;
                    r_valid      <= 1'b1;
                end else if (!r_full) begin
                    r_tail_sum   <= w_final;
                    r_tail_alarm <= w_alarm_new;
                    r_full       <= 1'b1;
                end else begin
                    r_drop <= 1'b1;
                end
            end else if (w_push && w_pop) begin
                if (r_full) begin
                    r_head_sum   <= r_tail_sum;
                    r_head_alarm <= r_tail_alarm;
                    r_tail_sum   <= w_final;
                    r_tail_alarm <= w_alarm_new;
                end else begin
                    r_head_sum   <= w_final;
                    r_head_alarm <= w_alarm_new;
                end
            end else if (w_pop) begin
                if (r_full) begin
                    r_head_sum   <= r_tail_sum;
                    r_head_alarm <= r_tail_alarm;
                    r_full       <= 1'b0;
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign win_sum   = r_head_sum;
    assign win_alarm = r_head_alarm;
    assign win_valid = r_valid;
    assign drop      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_ones_window_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ones_window_monitor
// Description : Directed self-checking bench for ones_window_monitor. A small
//               model of the upstream ones counter is fed from a per-phase
//               data pattern; expected window sums are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ones_window_monitor;

    logic       clk;
    logic       reset;
    logic [3:0] count;
    logic [7:0] win_sum;
    logic       win_alarm;
    logic       win_valid;
    logic       win_ready;
    logic       drop;

    logic [7:0] phase;
    logic       data;
    int         mode;
    int         checks;
    int         failures;

    ones_window_monitor #(
        .CNT_W  (4),
        .WIN_LEN(16),
        .SUM_W  (8),
        .THRESH (12)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .count    (count),
        .win_sum  (win_sum),
        .win_alarm(win_alarm),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .drop     (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data pattern per mode; mode 4 gives window sums 16, 0, 8, 12 repeating.
    always_comb begin
        data = 1'b0;
        case (mode)
            1: data = 1'b1;
            2: data = ~phase[0];
            3: data = (phase[3:0] < 4'd12);
            4: begin
                case (phase[5:4])
                    2'd0: data = 1'b1;
                    2'd1: data = 1'b0;
                    2'd2: data = ~phase[0];
                    default: data = (phase[3:0] < 4'd12);
                endcase
            end
            default: data = 1'b0;
        endcase
    end

    // Upstream ones counter model sharing the monitor's reset.
    always @(posedge clk) begin
        if (reset) begin
            phase <= '0;
            count <= '0;
        end else begin
            phase <= phase + 8'd1;
            count <= count + {3'b000, data};
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit got, output int ncyc, output bit saw_drop);
        got = 1'b0; ncyc = 0; saw_drop = 1'b0;
        while (!got && ncyc < budget) begin
            @(negedge clk);
            ncyc++;
            if (drop) saw_drop = 1'b1;
            if (win_valid) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        mode = 0; win_ready = 1'b0; reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (win_sum !== 8'd0) begin failures++; $display("FAIL rst_sum got=%0d exp=0", win_sum); end
        checks++; if (win_alarm !== 1'b0) begin failures++; $display("FAIL rst_alarm got=%0b exp=0", win_alarm); end
        checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", win_valid); end
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL rst_drop got=%0b exp=0", drop); end
    endtask

    task automatic test_ones();
        bit got; int n; bit sd;
        mode = 1; win_ready = 1'b1;
        do_reset();
        for (int w = 0; w < 2; w++) begin
            wait_valid(40, got, n, sd);
            checks++; if (got !== 1'b1) begin failures++; $display("FAIL ones_w%0d_timeout got=%0b exp=1", w, got); end
            checks++; if (n != (w == 0 ? 17 : 16)) begin failures++; $display("FAIL ones_w%0d_latency got=%0d exp=%0d", w, n, (w == 0 ? 17 : 16)); end
            checks++; if (win_sum !== 8'd16) begin failures++; $display("FAIL ones_w%0d_sum got=%0d exp=16", w, win_sum); end
            checks++; if (win_alarm !== 1'b1) begin failures++; $display("FAIL ones_w%0d_alarm got=%0b exp=1", w, win_alarm); end
        end
    endtask

    task automatic test_zeros();
        bit got; int n; bit sd; bit any_drop;
        mode = 0; win_ready = 1'b1; any_drop = 1'b0;
        do_reset();
        for (int w = 0; w < 2; w++) begin
            wait_valid(40, got, n, sd);
            any_drop = any_drop | sd;
            checks++; if (n != (w == 0 ? 17 : 16)) begin failures++; $display("FAIL zeros_w%0d_period got=%0d exp=%0d", w, n, (w == 0 ? 17 : 16)); end
            checks++; if (win_sum !== 8'd0) begin failures++; $display("FAIL zeros_w%0d_sum got=%0d exp=0", w, win_sum); end
            checks++; if (win_alarm !== 1'b0) begin failures++; $display("FAIL zeros_w%0d_alarm got=%0b exp=0", w, win_alarm); end
        end
        checks++; if (any_drop !== 1'b0) begin failures++; $display("FAIL zeros_drop got=%0b exp=0", any_drop); end
    endtask

    task automatic test_patterns();
        bit got; int n; bit sd;
        mode = 2; win_ready = 1'b1;
        do_reset();
        wait_valid(40, got, n, sd);
        checks++; if (win_sum !== 8'd8) begin failures++; $display("FAIL alt_sum got=%0d exp=8", win_sum); end
        checks++; if (win_alarm !== 1'b0) begin failures++; $display("FAIL alt_alarm got=%0b exp=0", win_alarm); end
        mode = 3;
        do_reset();
        wait_valid(40, got, n, sd);
        checks++; if (win_sum !== 8'd12) begin failures++; $display("FAIL thresh_sum got=%0d exp=12", win_sum); end
        checks++; if (win_alarm !== 1'b1) begin failures++; $display("FAIL thresh_alarm got=%0b exp=1", win_alarm); end
    endtask

    task automatic test_backpressure();
        bit got; int n; bit sd;
        mode = 4; win_ready = 1'b0;
        do_reset();
        repeat (17) @(negedge clk);
        checks++; if (win_valid !== 1'b1 || win_sum !== 8'd16) begin failures++; $display("FAIL bp_first got=%0b/%0d exp=1/16", win_valid, win_sum); end
        repeat (16) @(negedge clk);
        checks++; if (drop !== 1'b0 || win_sum !== 8'd16) begin failures++; $display("FAIL bp_second drop/sum got=%0b/%0d exp=0/16", drop, win_sum); end
        repeat (16) @(negedge clk);
        checks++; if (drop !== 1'b1) begin failures++; $display("FAIL bp_drop_pulse got=%0b exp=1", drop); end
        checks++; if (win_sum !== 8'd16) begin failures++; $display("FAIL bp_hold_sum got=%0d exp=16", win_sum); end
        @(negedge clk);
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL bp_drop_end got=%0b exp=0", drop); end
        win_ready = 1'b1;
        @(negedge clk);
        checks++; if (win_valid !== 1'b1 || win_sum !== 8'd0) begin failures++; $display("FAIL bp_second_out got=%0b/%0d exp=1/0", win_valid, win_sum); end
        @(negedge clk);
        checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0b exp=0", win_valid); end
        wait_valid(40, got, n, sd);
        checks++; if (n != 13) begin failures++; $display("FAIL bp_next_latency got=%0d exp=13", n); end
        checks++; if (win_sum !== 8'd12 || win_alarm !== 1'b1) begin failures++; $display("FAIL bp_next_sum got=%0d/%0b exp=12/1", win_sum, win_alarm); end
    endtask

    task automatic test_full_close();
        mode = 4; win_ready = 1'b0;
        do_reset();
        repeat (48) @(negedge clk);
        checks++; if (win_valid !== 1'b1 || win_sum !== 8'd16) begin failures++; $display("FAIL fc_head got=%0b/%0d exp=1/16", win_valid, win_sum); end
        win_ready = 1'b1;
        @(negedge clk);
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL fc_no_drop got=%0b exp=0", drop); end
        checks++; if (win_valid !== 1'b1 || win_sum !== 8'd0) begin failures++; $display("FAIL fc_second got=%0b/%0d exp=1/0", win_valid, win_sum); end
        @(negedge clk);
        checks++; if (win_valid !== 1'b1 || win_sum !== 8'd8 || win_alarm !== 1'b0) begin failures++; $display("FAIL fc_third got=%0b/%0d/%0b exp=1/8/0", win_valid, win_sum, win_alarm); end
        @(negedge clk);
        checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL fc_empty got=%0b exp=0", win_valid); end
    endtask

    task automatic test_reset_mid();
        bit got; int n; bit sd;
        mode = 1; win_ready = 1'b0;
        do_reset();
        repeat (24) @(negedge clk);
        checks++; if (win_valid !== 1'b1) begin failures++; $display("FAIL rm_pending got=%0b exp=1", win_valid); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL rm_flush got=%0b exp=0", win_valid); end
        reset = 1'b0;
        wait_valid(40, got, n, sd);
        checks++; if (n != 17) begin failures++; $display("FAIL rm_latency got=%0d exp=17", n); end
        checks++; if (win_sum !== 8'd16) begin failures++; $display("FAIL rm_sum got=%0d exp=16", win_sum); end
    endtask

    initial begin
        checks = 0; failures = 0;
        mode = 0; reset = 1'b1; win_ready = 1'b0;
        test_reset();
        test_ones();
        test_zeros();
        test_patterns();
        test_backpressure();
        test_full_close();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
